// File: rtl/twi_pkg.sv
// Shared types and constants for the TWI byte engine.
package twi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } twi_state_e;

    typedef struct packed {
        logic start;
        logic stop;
        logic read;
        logic nack;
    } twi_cmd_t;

    localparam int   QTR_W    = 2;
    localparam int   BIT_W    = 3;
    localparam int   CMD_W    = $bits(twi_cmd_t);
    localparam logic LINE_REL = 1'b1;

endpackage

// File: rtl/twi_quarter_timer.sv
// Quarter-period prescaler; tick_o is high on the last cycle of every SCL quarter.
module twi_quarter_timer #(
    parameter int CLK_DIV   = 250,
    parameter int DIV_WIDTH = 16
) (
    input  logic iClk,
    input  logic iResetN,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(CLK_DIV - 1);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tick_o ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/twi_master_engine.sv
// Byte-level TWI master: optional START, 8 data bits + ACK, optional STOP per command.
//   state    | meaning
//   IDLE     | ready for a command, lines held
//   START    | (repeated) START condition, 4 quarters
//   BIT      | one data bit per 4 quarters, 8 times
//   ACK      | acknowledge slot
//   STOP     | STOP condition, releases the bus
//   DONE     | one cycle, publishes results
module twi_master_engine
    import twi_pkg::*;
#(
    parameter int CLK_DIV   = 250,
    parameter int DIV_WIDTH = 16
) (
    input  logic       iClk,
    input  logic       iResetN,
    input  logic       iCmdValid,
    output logic       oCmdReady,
    input  logic       iCmdStart,
    input  logic       iCmdStop,
    input  logic       iCmdRead,
    input  logic       iCmdNack,
    input  logic [0:7] iTxData,
    output logic [0:7] oRxData,
    output logic       oAckErr,
    output logic       oDone,
    output logic       oBusOwned,
    input  logic       iSda,
    output logic       oSda,
    output logic       oScl
);

    twi_state_e       state_q, state_d;
    logic [QTR_W-1:0] qtr_q, qtr_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    twi_cmd_t         cmd_q, cmd_d;
    logic [0:7]       tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
    logic             ack_smp_q, ack_smp_d, ack_err_q, ack_err_d;
    logic             done_q, done_d, ready_q, ready_d, owned_q, owned_d;
    logic             scl_q, scl_d, sda_q, sda_d;
    logic [CMD_W-1:0] cmd_in;
    logic             accept, busy, tick;

    assign cmd_in = {iCmdStart, iCmdStop, iCmdRead, iCmdNack};
    assign accept = iCmdValid && ready_q;
    assign busy   = state_q inside {ST_START, ST_BIT, ST_ACK, ST_STOP};

    twi_quarter_timer #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(DIV_WIDTH)) u_timer (
        .iClk    (iClk),
        .iResetN (iResetN),
        .en_i    (busy),
        .clr_i   (accept),
        .tick_o  (tick)
    );

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        cmd_d     = cmd_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_d      = rx_q;
        ack_smp_d = ack_smp_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        ready_d   = ready_q;
        owned_d   = owned_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    cmd_d     = twi_cmd_t'(cmd_in);
                    tx_d      = iTxData;
                    ready_d   = 1'b0;
                    ack_err_d = 1'b0;
                    qtr_d     = '0;
                    bit_d     = '0;
                    // An unowned bus always needs a START first
                    if (iCmdStart || !owned_q) begin
                        state_d = ST_START;
                        owned_d = 1'b1;
                    end else begin
                        state_d = ST_BIT;
                    end
                end
            end
            ST_START, ST_BIT, ST_ACK, ST_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + QTR_W'(1);
                    if (qtr_q == QTR_W'(2) && state_q == ST_BIT) rx_sh_d = {rx_sh_q[1:7], iSda};
                    if (qtr_q == QTR_W'(2) && state_q == ST_ACK) ack_smp_d = iSda;
                    if (qtr_q == QTR_W'(3)) begin
                        case (state_q)
                            ST_START: state_d = ST_BIT;
                            ST_BIT: begin
                                bit_d = bit_q + BIT_W'(1);
                                if (bit_q == '1) state_d = ST_ACK;
                            end
                            ST_ACK:  state_d = cmd_q.stop ? ST_STOP : ST_DONE;
                            default: begin
                                state_d = ST_DONE;
                                owned_d = 1'b0;
                            end
                        endcase
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                done_d    = 1'b1;
                if (cmd_q.read) rx_d = rx_sh_q;
                ack_err_d = !cmd_q.read && ack_smp_q;
            end
            default: state_d = ST_IDLE;
        endcase

        // Lines are derived from the quarter being entered so they change only at quarter entry
        scl_d = scl_q;
        sda_d = sda_q;
        case (state_d)
            ST_START: begin scl_d = (qtr_d != '0); sda_d = ~qtr_d[1]; end
            ST_BIT: begin
                scl_d = qtr_d[1];
                sda_d = cmd_d.read ? LINE_REL : tx_d[bit_d];
            end
            ST_ACK: begin
                scl_d = qtr_d[1];
                sda_d = cmd_d.read ? cmd_d.nack : LINE_REL;
            end
            ST_STOP: begin scl_d = (qtr_d != '0); sda_d = qtr_d[1]; end
            ST_DONE: if (!cmd_d.stop) scl_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            state_q   <= ST_IDLE;
            qtr_q     <= '0;
            bit_q     <= '0;
            cmd_q     <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            ack_smp_q <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            owned_q   <= 1'b0;
            scl_q     <= LINE_REL;
            sda_q     <= LINE_REL;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            cmd_q     <= cmd_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_q      <= rx_d;
            ack_smp_q <= ack_smp_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            owned_q   <= owned_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
        end
    end

    assign oCmdReady = ready_q;
    assign oRxData   = rx_q;
    assign oAckErr   = ack_err_q;
    assign oDone     = done_q;
    assign oBusOwned = owned_q;
    assign oSda      = sda_q;
    assign oScl      = scl_q;

endmodule

// File: tb/tb_twi_master_engine.sv
// Scoreboard bench for twi_master_engine: a transaction-level model predicts each command's
// results and the SDA level at every SCL rise; a monitor compares on every oDone.
module tb_twi_master_engine;

    localparam int D = 4;

    logic       iClk = 1'b0;
    logic       iResetN = 1'b1;
    logic       iCmdValid = 1'b0, iCmdStart = 1'b0, iCmdStop = 1'b0;
    logic       iCmdRead = 1'b0, iCmdNack = 1'b0;
    logic [0:7] iTxData = '0;
    logic [0:7] oRxData;
    logic       oCmdReady, oAckErr, oDone, oBusOwned, oSda, oScl, iSda;
    logic       slave_sda = 1'b1;

    assign iSda = oSda & slave_sda;

    twi_master_engine #(.CLK_DIV(D), .DIV_WIDTH(16)) dut (
        .iClk(iClk), .iResetN(iResetN), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
        .iCmdStart(iCmdStart), .iCmdStop(iCmdStop), .iCmdRead(iCmdRead), .iCmdNack(iCmdNack),
        .iTxData(iTxData), .oRxData(oRxData), .oAckErr(oAckErr), .oDone(oDone),
        .oBusOwned(oBusOwned), .iSda(iSda), .oSda(oSda), .oScl(oScl)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc++;

    // bus observer and slave model
    bit         rise_q[$];
    int         n_st = 0, n_sp = 0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         sl_base = 0, sl_first = 0;
    logic       sl_read = 1'b0, sl_ack = 1'b0;
    logic [7:0] sl_byte = '0;

    function automatic logic slave_bit(input int k);
        int j;
        j = k - sl_first;
        if (sl_read && j >= 0 && j < 8) return sl_byte[7-j];
        if (!sl_read && j == 8) return sl_ack;
        return 1'b1;
    endfunction

    always @(negedge iClk) begin
        if (!prev_scl && oScl) rise_q.push_back(iSda);
        if (prev_scl && oScl && prev_sda != iSda) begin
            if (!iSda) n_st++;
            else       n_sp++;
        end
        prev_scl = oScl;
        prev_sda = iSda;
        if (!iResetN)  slave_sda = 1'b1;
        else if (!oScl) slave_sda = slave_bit(rise_q.size() - sl_base);
    end

    typedef struct {
        int          acc;
        int          lat;
        logic [7:0]  rx;
        logic        ack;
        logic        own;
        logic        scl;
        int          rbase;
        int          nr;
        logic [15:0] seq;
        int          sbase;
        int          pbase;
        int          nst;
        int          nsp;
    } exp_t;

    exp_t       exp_q[$];
    int         rst_q[$];
    logic       own_m = 1'b0;
    logic [7:0] rx_m = '0;

    // scoreboard monitor
    int n_cmp = 0, n_bad = 0;
    bit post_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge iClk) begin
        exp_t        e;
        logic [15:0] aseq;
        if (post_chk) begin
            post_chk = 0;
            chk("done_pulse_width", oDone, 1'b0);
            chk("ready_after_done", oCmdReady, 1'b1);
        end
        if (!iResetN && rst_q.size() > 0) begin
            void'(rst_q.pop_front());
            chk("rst_scl", oScl, 1'b1);
            chk("rst_sda", oSda, 1'b1);
            chk("rst_ready", oCmdReady, 1'b1);
            chk("rst_owned", oBusOwned, 1'b0);
            chk("rst_done", oDone, 1'b0);
            chk("rst_ackerr", oAckErr, 1'b0);
            chk("rst_rxdata", oRxData, 8'h00);
        end else if (iResetN && oDone) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", oDone, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("latency", cyc - e.acc, e.lat);
                chk("rx_data", oRxData, e.rx);
                chk("ack_err", oAckErr, e.ack);
                chk("bus_owned", oBusOwned, e.own);
                chk("scl_after", oScl, e.scl);
                if (e.scl) chk("sda_after", oSda, 1'b1);
                aseq = '0;
                for (int i = 0; i < e.nr && e.rbase + i < rise_q.size(); i++)
                    aseq = {aseq[14:0], rise_q[e.rbase+i]};
                chk("rise_count", rise_q.size() - e.rbase, e.nr);
                chk("sda_at_rises", aseq, e.seq);
                chk("start_conds", n_st - e.sbase, e.nst);
                chk("stop_conds", n_sp - e.pbase, e.nsp);
                post_chk = 1;
            end
        end
    end

    // stimulus with transaction-level reference model
    task automatic issue(input logic st, input logic sp, input logic rd, input logic nk,
                         input logic [7:0] tx, input logic [7:0] sbyte, input logic sack,
                         input bit poke, input bit track);
        exp_t e;
        int   se, waited;
        @(negedge iClk);
        waited = 0;
        while (!oCmdReady) begin
            @(negedge iClk);
            waited++;
            if (waited > 2000) begin
                $display("FAIL ready_timeout: oCmdReady=%0b after %0d cycles, expected 1", oCmdReady, waited);
                $fatal(1, "ready wait expired");
            end
        end
        se       = (st || !own_m) ? 1 : 0;
        sl_first = se;
        sl_read  = rd;
        sl_byte  = sbyte;
        sl_ack   = sack;
        sl_base  = rise_q.size();
        iCmdStart = st; iCmdStop = sp; iCmdRead = rd; iCmdNack = nk; iTxData = tx;
        iCmdValid = 1'b1;
        @(posedge iClk);
        #1;
        iCmdValid = 1'b0;
        iCmdStart = 1'($urandom); iCmdStop = 1'($urandom); iCmdRead = 1'($urandom);
        iCmdNack  = 1'($urandom); iTxData = 8'($urandom);
        e.acc = cyc;
        e.lat = 4 * (9 + se + (sp ? 1 : 0)) * D + 1;
        e.seq = '0;
        e.nr  = 0;
        if (se == 1) begin e.seq = {e.seq[14:0], 1'b1}; e.nr++; end
        for (int j = 0; j < 8; j++) begin
            e.seq = {e.seq[14:0], rd ? sbyte[7-j] : tx[7-j]};
            e.nr++;
        end
        e.seq = {e.seq[14:0], rd ? nk : sack};
        e.nr++;
        if (sp) begin e.seq = {e.seq[14:0], 1'b0}; e.nr++; end
        if (rd) rx_m = sbyte;
        own_m   = !sp;
        e.rx    = rx_m;
        e.ack   = rd ? 1'b0 : sack;
        e.own   = own_m;
        e.scl   = sp;
        e.rbase = sl_base;
        e.sbase = n_st;
        e.pbase = n_sp;
        e.nst   = se;
        e.nsp   = sp ? 1 : 0;
        if (track) exp_q.push_back(e);
        if (poke) begin
            repeat (60) @(negedge iClk);
            iCmdValid = 1'b1; iCmdStart = 1'b1; iCmdStop = ~sp; iCmdRead = ~rd; iTxData = ~tx;
            @(negedge iClk);
            iCmdValid = 1'b0;
        end
    endtask

    initial begin
        int waited;
        rst_q.push_back(1);
        #1 iResetN = 1'b0;
        repeat (3) @(posedge iClk);
        #2 iResetN = 1'b1;

        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 1);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1, 0, 1);
        issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h96, 1'b0, 0, 1);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 0, 1);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, 8'h00, 1'b0, 1, 1);

        // abort a read partway through the byte
        issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hE7, 1'b0, 0, 0);
        waited = 0;
        while (rise_q.size() < sl_base + sl_first + 4) begin
            @(negedge iClk);
            waited++;
            if (waited > 400) begin
                $display("FAIL bit4_timeout: saw %0d rises, expected %0d", rise_q.size() - sl_base, sl_first + 4);
                $fatal(1, "bit wait expired");
            end
        end
        repeat (2 * D + 2) @(negedge iClk);
        @(posedge iClk);
        #2;
        rst_q.push_back(1);
        iResetN = 1'b0;
        own_m = 1'b0;
        rx_m  = '0;
        repeat (2) @(posedge iClk);
        #2 iResetN = 1'b1;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h6B, 8'h00, 1'b0, 0, 1);

        for (int n = 0; n < 24; n++)
            issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom), 0, 1);

        waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(negedge iClk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL drain_timeout: %0d commands without oDone, expected 0", exp_q.size());
            $fatal(1, "drain wait expired");
        end
        repeat (4) @(negedge iClk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
